data_mem_resp: RTL and testbench



---
 rtl/data_mem_resp.sv | 152 +++++++++++++++
 tb/tb_data_mem_resp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: multi-cycle data-memory responder for the core load/store port.
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high; a source holds its payload stable until then.
// One transaction is outstanding at a time: req_ready = (state==IDLE),
// rsp_valid = (state==RESP).
module data_mem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LAT4  = 4'(LATENCY);

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH+1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic [1:0]              r_size;
  logic                    r_uns;
  logic [31:0]             r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_access;
  logic                    w_err;
  logic                    w_mem_we;
  logic [31:0]             w_word;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [31:0]             w_load;
  logic [3:0]              w_be;
  logic [31:0]             w_wdata_rep;
  logic                    w_unused_addr;

  // Upper address bits alias onto the array and are intentionally dropped.
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign w_idx     = r_addr[ADDR_WIDTH+1:2];
  // r_cnt counts the remaining wait cycles; the access edge is the one where it is 0,
  // which places rsp_valid LATENCY+1 edges after acceptance.
  assign w_access  = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_mem_we  = w_access && r_we && !w_err && !reset;
  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign dbg_state = r_state;

  // Decode alignment/size errors, load lane extraction and store byte enables.
  always_comb begin
    w_err       = 1'b0;
    w_word      = r_mem[w_idx];
    w_byte      = w_word[8*r_addr[1:0] +: 8];
    w_half      = r_addr[1] ? w_word[31:16] : w_word[15:0];
    w_load      = w_word;
    w_be        = 4'b0000;
    w_wdata_rep = r_wdata;
    case (r_size)
      2'b00: begin
        w_load      = r_uns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
        w_be        = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_err       = r_addr[0];
        w_load      = r_uns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
        w_be        = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_err       = (r_addr[1:0] != 2'b00);
        w_load      = w_word;
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
      default: begin
        w_err = 1'b1;
      end
    endcase
  end

  // Transaction FSM: accept, count latency, access, hold response until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_size    <= 2'b00;
      r_uns     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr[ADDR_WIDTH+1:0];
            r_wdata <= req_wdata;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_cnt   <= LAT4;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            rsp_err   <= w_err;
            rsp_rdata <= (!w_err && !r_we) ? w_load : 32'd0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte-lane store into the array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: one instance at LATENCY=2 and one at LATENCY=0,
// selected by sel; both share the request payload, reset and clock.
module tb_data_mem_resp;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready2, rsp_valid2, rsp_err2;
  logic [31:0] rsp_rdata2;
  logic [1:0]  dbg_state2;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [1:0]  dbg_state0;

  logic        m_req_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_rsp_rdata;
  logic [1:0]  m_dbg_state;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel), .req_ready(req_ready2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready & ~sel),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .dbg_state(dbg_state2)
  );

  data_mem_resp #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel), .req_ready(req_ready0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready & sel),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .dbg_state(dbg_state0)
  );

  assign m_req_ready = sel ? req_ready0 : req_ready2;
  assign m_rsp_valid = sel ? rsp_valid0 : rsp_valid2;
  assign m_rsp_err   = sel ? rsp_err0   : rsp_err2;
  assign m_rsp_rdata = sel ? rsp_rdata0 : rsp_rdata2;
  assign m_dbg_state = sel ? dbg_state0 : dbg_state2;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: present one request and hold it until accepted
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    int n;
    n = 0;
    @(negedge clk);
    while (!m_req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", {31'b0, m_req_ready}, 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // driver/monitor: wait for response, optionally back-pressure, then take it
  task automatic expect_rsp(input string tag, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_lat, input int hold);
    int n;
    n = 0;
    while (!m_rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".rdata"}, m_rsp_rdata, exp_rdata);
    chk({tag, ".err"}, {31'b0, m_rsp_err}, {31'b0, exp_err});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {31'b0, m_rsp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, m_rsp_rdata, exp_rdata);
      chk({tag, ".hold_rdy"}, {31'b0, m_req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, {31'b0, m_rsp_valid}, 32'd0);
    chk({tag, ".post_rdy"}, {31'b0, m_req_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    issue(we, addr, wdata, size, uns);
    expect_rsp(tag, exp_rdata, exp_err, exp_lat, 0);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_size = SZ_W; req_unsigned = 1'b0;
    do_reset();

    chk("rst.req_ready", {31'b0, m_req_ready}, 32'd1);
    chk("rst.rsp_valid", {31'b0, m_rsp_valid}, 32'd0);
    chk("rst.rdata", m_rsp_rdata, 32'd0);
    chk("rst.err", {31'b0, m_rsp_err}, 32'd0);
    chk("rst.state", {30'b0, m_dbg_state}, 32'd0);

    // LATENCY=2: response 3 edges after acceptance
    txn("sw10",   1'b1, 32'h10, 32'h11223344, SZ_W, 1'b0, 32'h0,        1'b0, 3);
    txn("lw10a",  1'b0, 32'h10, 32'h0,        SZ_W, 1'b0, 32'h11223344, 1'b0, 3);
    txn("sb11",   1'b1, 32'h11, 32'h000000AB, SZ_B, 1'b0, 32'h0,        1'b0, 3);
    txn("lw10b",  1'b0, 32'h10, 32'h0,        SZ_W, 1'b0, 32'h1122AB44, 1'b0, 3);
    txn("lb11",   1'b0, 32'h11, 32'h0,        SZ_B, 1'b0, 32'hFFFFFFAB, 1'b0, 3);
    txn("lbu11",  1'b0, 32'h11, 32'h0,        SZ_B, 1'b1, 32'h000000AB, 1'b0, 3);
    txn("sh12",   1'b1, 32'h12, 32'h00008001, SZ_H, 1'b0, 32'h0,        1'b0, 3);
    txn("lh12",   1'b0, 32'h12, 32'h0,        SZ_H, 1'b0, 32'hFFFF8001, 1'b0, 3);
    txn("lhu12",  1'b0, 32'h12, 32'h0,        SZ_H, 1'b1, 32'h00008001, 1'b0, 3);
    txn("lw10c",  1'b0, 32'h10, 32'h0,        SZ_W, 1'b0, 32'h8001AB44, 1'b0, 3);
    // error cases: no write, zero data
    txn("lw13",   1'b0, 32'h13, 32'h0,        SZ_W, 1'b0, 32'h0,        1'b1, 3);
    txn("sh11",   1'b1, 32'h11, 32'h0000FFFF, SZ_H, 1'b0, 32'h0,        1'b1, 3);
    txn("szx",    1'b1, 32'h10, 32'h0,        SZ_X, 1'b0, 32'h0,        1'b1, 3);
    txn("lw10d",  1'b0, 32'h10, 32'h0,        SZ_W, 1'b0, 32'h8001AB44, 1'b0, 3);
    // upper address bits alias onto the same word
    txn("alias",  1'b0, 32'h1010, 32'h0,      SZ_W, 1'b0, 32'h8001AB44, 1'b0, 3);
    // backpressure for 5 cycles
    issue(1'b0, 32'h10, 32'h0, SZ_W, 1'b0);
    expect_rsp("bp", 32'h8001AB44, 1'b0, 3, 5);

    // reset while in WAIT drops the store and the response
    txn("sw20",   1'b1, 32'h20, 32'h55AA55AA, SZ_W, 1'b0, 32'h0,        1'b0, 3);
    issue(1'b1, 32'h20, 32'hDEADBEEF, SZ_W, 1'b0);
    chk("rw.state", {30'b0, m_dbg_state}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rw.req_ready", {31'b0, m_req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("rw.no_rsp", {31'b0, m_rsp_valid}, 32'd0);
    txn("lw20",   1'b0, 32'h20, 32'h0,        SZ_W, 1'b0, 32'h55AA55AA, 1'b0, 3);

    // reset and req_valid on the same edge: request not taken
    @(negedge clk);
    reset = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
    req_size = SZ_W; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    chk("rv.state", {30'b0, m_dbg_state}, 32'd0);
    repeat (4) @(negedge clk);
    chk("rv.no_rsp", {31'b0, m_rsp_valid}, 32'd0);
    txn("lw20b",  1'b0, 32'h20, 32'h0,        SZ_W, 1'b0, 32'h55AA55AA, 1'b0, 3);

    // LATENCY=0 instance: response one edge after acceptance
    sel = 1'b1;
    txn("z.sw40", 1'b1, 32'h40, 32'hCAFEF00D, SZ_W, 1'b0, 32'h0,        1'b0, 1);
    txn("z.lw40", 1'b0, 32'h40, 32'h0,        SZ_W, 1'b0, 32'hCAFEF00D, 1'b0, 1);
    txn("z.lb43", 1'b0, 32'h43, 32'h0,        SZ_B, 1'b0, 32'hFFFFFFCA, 1'b0, 1);
    txn("z.lhu42",1'b0, 32'h42, 32'h0,        SZ_H, 1'b1, 32'h0000CAFE, 1'b0, 1);
    issue(1'b1, 32'h40, 32'h12345678, SZ_W, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("z.rw.no_rsp", {31'b0, m_rsp_valid}, 32'd0);
    txn("z.lw40b",1'b0, 32'h40, 32'h0,        SZ_W, 1'b0, 32'hCAFEF00D, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
